// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIT FFT address sequencer: issues butterfly operand/twiddle reads per stage
// and replays the operand addresses as write-backs after the read+butterfly pipeline latency.
module fft_addr_gen #(
    parameter int unsigned LOG2N    = 10,
    parameter int unsigned PIPE_LAT = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       rd_en_o,
    output logic [LOG2N-1:0]           rd_addr_p_o,
    output logic [LOG2N-1:0]           rd_addr_q_o,
    output logic [LOG2N-2:0]           tw_addr_o,
    output logic [$clog2(LOG2N)-1:0]   rd_stage_o,
    output logic                       wr_en_o,
    output logic [LOG2N-1:0]           wr_addr_p_o,
    output logic [LOG2N-1:0]           wr_addr_q_o
);

    localparam int SW = $clog2(LOG2N);
    localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    localparam logic [LOG2N-2:0] KLast    = '1;
    localparam logic [SW-1:0]    SLast    = SW'(LOG2N - 1);
    localparam logic [CW-1:0]    CntLast  = CW'(PIPE_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             busy_q, done_q, rd_en_q;
    logic [LOG2N-1:0] rd_p_q, rd_q_q;
    logic [LOG2N-2:0] tw_q;
    logic [SW-1:0]    stage_q;

    logic             dl_v_q [PIPE_LAT];
    logic [LOG2N-1:0] dl_p_q [PIPE_LAT];
    logic [LOG2N-1:0] dl_q_q [PIPE_LAT];

    logic [LOG2N-1:0] kk, half, mask, m, p_d, q_d, tw_full;
    logic [SW-1:0]    tw_sh;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            StRun: begin
                if (k_q == KLast) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                if (cnt_q == CntLast) begin
                    if (s_q != SLast) begin
                        state_d = StRun;
                        s_d     = s_q + 1'b1;
                        k_d     = '0;
                    end else begin
                        state_d = StFinish;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Addresses are computed for the read issued in the next cycle, so outputs stay registered.
    always_comb begin
        kk      = {1'b0, k_d};
        half    = LOG2N'(1) << s_d;
        mask    = ~({LOG2N{1'b1}} << s_d);
        m       = kk & mask;
        p_d     = (((kk >> s_d) << s_d) << 1) | m;
        q_d     = p_d | half;
        tw_sh   = SLast - s_d;
        tw_full = m << tw_sh;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            k_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_p_q  <= '0;
            rd_q_q  <= '0;
            tw_q    <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == StRun) || (state_d == StDrain);
            done_q  <= (state_d == StFinish);
            rd_en_q <= (state_d == StRun);
            if (state_d == StRun) begin
                rd_p_q  <= p_d;
                rd_q_q  <= q_d;
                tw_q    <= tw_full[LOG2N-2:0];
                stage_q <= s_d;
            end
        end
    end

    // Each stage keeps the address of the last valid entry, so write addresses hold when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                dl_v_q[i] <= 1'b0;
                dl_p_q[i] <= '0;
                dl_q_q[i] <= '0;
            end
        end else begin
            dl_v_q[0] <= rd_en_q;
            if (rd_en_q) begin
                dl_p_q[0] <= rd_p_q;
                dl_q_q[0] <= rd_q_q;
            end
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                dl_v_q[i] <= dl_v_q[i-1];
                if (dl_v_q[i-1]) begin
                    dl_p_q[i] <= dl_p_q[i-1];
                    dl_q_q[i] <= dl_q_q[i-1];
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_p_o = rd_p_q;
    assign rd_addr_q_o = rd_q_q;
    assign tw_addr_o   = tw_q;
    assign rd_stage_o  = stage_q;
    assign wr_en_o     = dl_v_q[PIPE_LAT-1];
    assign wr_addr_p_o = dl_p_q[PIPE_LAT-1];
    assign wr_addr_q_o = dl_q_q[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench: three fft_addr_gen instances (N=8/lat5, N=8/lat1, N=1024/lat5) compared
// every cycle against a closed-form cycle-indexed reference model.
module tb_fft_addr_gen;

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic start_a, start_b, start_c;

    logic       a_busy, a_done, a_rd_en, a_wr_en;
    logic [2:0] a_rp, a_rq, a_wp, a_wq;
    logic [1:0] a_tw, a_st;

    logic       b_busy, b_done, b_rd_en, b_wr_en;
    logic [2:0] b_rp, b_rq, b_wp, b_wq;
    logic [1:0] b_tw, b_st;

    logic       c_busy, c_done, c_rd_en, c_wr_en;
    logic [9:0] c_rp, c_rq, c_wp, c_wq;
    logic [8:0] c_tw;
    logic [3:0] c_st;

    fft_addr_gen #(.LOG2N(3), .PIPE_LAT(5)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .busy_o(a_busy), .done_o(a_done),
        .rd_en_o(a_rd_en), .rd_addr_p_o(a_rp), .rd_addr_q_o(a_rq), .tw_addr_o(a_tw),
        .rd_stage_o(a_st), .wr_en_o(a_wr_en), .wr_addr_p_o(a_wp), .wr_addr_q_o(a_wq)
    );

    fft_addr_gen #(.LOG2N(3), .PIPE_LAT(1)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .busy_o(b_busy), .done_o(b_done),
        .rd_en_o(b_rd_en), .rd_addr_p_o(b_rp), .rd_addr_q_o(b_rq), .tw_addr_o(b_tw),
        .rd_stage_o(b_st), .wr_en_o(b_wr_en), .wr_addr_p_o(b_wp), .wr_addr_q_o(b_wq)
    );

    fft_addr_gen #(.LOG2N(10), .PIPE_LAT(5)) dut_c (
        .clk_i(clk), .rst_i(rst_c), .start_i(start_c), .busy_o(c_busy), .done_o(c_done),
        .rd_en_o(c_rd_en), .rd_addr_p_o(c_rp), .rd_addr_q_o(c_rq), .tw_addr_o(c_tw),
        .rd_stage_o(c_st), .wr_en_o(c_wr_en), .wr_addr_p_o(c_wp), .wr_addr_q_o(c_wq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc;

    int lg [3] = '{3, 3, 10};
    int pl [3] = '{5, 1, 5};
    int t  [3];
    int lp [3], lq [3], ltw [3], lst [3], lwp [3], lwq [3];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic longint pk(input int a, input int b, input int c, input int d, input int e);
        return (longint'(a) << 44) | (longint'(b) << 32) | (longint'(c) << 20) |
               (longint'(d) << 8) | longint'(e);
    endfunction

    // Read issued in cycle t (t=1 is the first cycle after start was accepted).
    function automatic void read_at(input int l, input int lat, input int tt, output bit en,
                                    output int p, output int q, output int tw, output int st);
        int h, per, s, r, half;
        h   = 2 ** (l - 1);
        per = h + lat;
        en = 0; p = 0; q = 0; tw = 0; st = 0;
        if (tt >= 1 && tt <= l * per) begin
            s = (tt - 1) / per;
            r = (tt - 1) % per;
            if (r < h) begin
                half = 2 ** s;
                p    = (r / half) * 2 * half + (r % half);
                q    = p + half;
                tw   = (r % half) * (2 ** (l - 1 - s));
                st   = s;
                en   = 1;
            end
        end
    endfunction

    task automatic model_edge(input int i, input logic rst, input logic start);
        int total;
        total = lg[i] * (2 ** (lg[i] - 1) + pl[i]);
        if (rst) begin
            t[i] = 0;
            lp[i] = 0; lq[i] = 0; ltw[i] = 0; lst[i] = 0; lwp[i] = 0; lwq[i] = 0;
        end else if (t[i] == 0) begin
            if (start) t[i] = 1;
        end else begin
            t[i] = (t[i] == total + 1) ? 0 : t[i] + 1;
        end
    endtask

    task automatic expect_now(input int i, output longint e_rd, output longint e_wr,
                              output longint e_ctl);
        bit en, wen;
        int p, q, tw, st, wp, wq, d0, d1, total;
        total = lg[i] * (2 ** (lg[i] - 1) + pl[i]);
        read_at(lg[i], pl[i], t[i], en, p, q, tw, st);
        if (en) begin
            lp[i] = p; lq[i] = q; ltw[i] = tw; lst[i] = st;
        end
        wen = 0;
        if (t[i] > 0) read_at(lg[i], pl[i], t[i] - pl[i], wen, wp, wq, d0, d1);
        if (wen) begin
            lwp[i] = wp; lwq[i] = wq;
        end
        e_rd  = pk(int'(en), lp[i], lq[i], ltw[i], lst[i]);
        e_wr  = pk(int'(wen), lwp[i], lwq[i], 0, 0);
        e_ctl = pk(int'(t[i] >= 1 && t[i] <= total), int'(t[i] == total + 1), 0, 0, 0);
    endtask

    initial begin
        longint e_rd, e_wr, e_ctl;
        int c_rd_cnt, c_wr_cnt, c_done_cnt, c_done_cyc;
        c_rd_cnt = 0; c_wr_cnt = 0; c_done_cnt = 0; c_done_cyc = -1;
        for (int i = 0; i < 3; i++) t[i] = 0;
        cyc = -3;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;

        while (cyc < 5400) begin
            @(posedge clk);
            model_edge(0, rst_a, start_a);
            model_edge(1, rst_b, start_b);
            model_edge(2, rst_c, start_c);
            cyc++;
            #1;
            if (cyc < 100) begin
                // Run at 0 with ignored starts at 5, 20, 28; new run at 29, reset at its cycle 12.
                rst_a   = (cyc < 0) || (cyc == 41);
                start_a = (cyc == 0) || (cyc == 5) || (cyc == 20) || (cyc == 28) ||
                          (cyc == 29) || (cyc == 41) || (cyc == 60);
            end else begin
                rst_a   = ($urandom_range(0, 399) == 0);
                start_a = ($urandom_range(0, 19) == 0);
            end
            rst_b   = (cyc < 0) || ((cyc > 50) && ($urandom_range(0, 299) == 0));
            start_b = (cyc >= 0) && ($urandom_range(0, 9) == 0);
            rst_c   = (cyc < 0);
            start_c = (cyc == 0);

            @(negedge clk);
            expect_now(0, e_rd, e_wr, e_ctl);
            check("a_rd", pk(int'(a_rd_en), int'(a_rp), int'(a_rq), int'(a_tw), int'(a_st)), e_rd);
            check("a_wr", pk(int'(a_wr_en), int'(a_wp), int'(a_wq), 0, 0), e_wr);
            check("a_ctl", pk(int'(a_busy), int'(a_done), 0, 0, 0), e_ctl);
            expect_now(1, e_rd, e_wr, e_ctl);
            check("b_rd", pk(int'(b_rd_en), int'(b_rp), int'(b_rq), int'(b_tw), int'(b_st)), e_rd);
            check("b_wr", pk(int'(b_wr_en), int'(b_wp), int'(b_wq), 0, 0), e_wr);
            check("b_ctl", pk(int'(b_busy), int'(b_done), 0, 0, 0), e_ctl);
            expect_now(2, e_rd, e_wr, e_ctl);
            check("c_rd", pk(int'(c_rd_en), int'(c_rp), int'(c_rq), int'(c_tw), int'(c_st)), e_rd);
            check("c_wr", pk(int'(c_wr_en), int'(c_wp), int'(c_wq), 0, 0), e_wr);
            check("c_ctl", pk(int'(c_busy), int'(c_done), 0, 0, 0), e_ctl);

            if (cyc >= 0) begin
                if (c_rd_en === 1'b1) c_rd_cnt++;
                if (c_wr_en === 1'b1) c_wr_cnt++;
                if (c_done === 1'b1) begin
                    c_done_cnt++;
                    if (c_done_cyc < 0) c_done_cyc = cyc;
                end
            end
        end

        check("c_rd_count", longint'(c_rd_cnt), 64'd5120);
        check("c_wr_count", longint'(c_wr_cnt), 64'd5120);
        check("c_done_cycle", longint'(c_done_cyc), 64'd5171);
        check("c_done_count", longint'(c_done_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
